regfile_dump_reader: RTL and testbench

//  Debug read-out engine for the ID-stage register file. On a start request it walks

---
 rtl/regfile_dump_reader.sv | 82 ++++++++
 tb/tb_regfile_dump_reader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: streams registers 0..NREG-1 as MSB-first bytes over valid/ready
//   clk      system clock
//   reset    asynchronous active-low reset
//   start    dump request, sampled only while idle
//   rd_addr  register file read address
//   rd_data  register file read data for rd_addr, same cycle
//   tx_data  byte to transmitter
//   tx_valid tx_data valid
//   tx_ready transmitter accepts byte
//   busy     high whenever not idle
//   done     one-cycle pulse after the last byte is accepted
module regfile_dump_reader #(
    parameter int B    = 32,
    parameter int W    = 5,
    parameter int NREG = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [W-1:0] rd_addr,
    input  logic [B-1:0] rd_data,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         busy,
    output logic         done
);
    localparam int NB = B / 8;
    localparam int CW = NB > 1 ? $clog2(NB) : 1;
    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
    state_t       state;
    logic [B-1:0] sr;
    logic [CW-1:0] byte_cnt;
    assign tx_data = sr[B-1 -: 8];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rd_addr  <= '0;
            sr       <= '0;
            byte_cnt <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    rd_addr <= '0;
                    busy    <= 1'b1;
                    state   <= LOAD;
                end
                LOAD: begin
                    sr       <= rd_data;
                    byte_cnt <= '0;
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end
                // tx_valid is always high here, so tx_ready alone marks acceptance
                SEND: if (tx_ready) begin
                    if (byte_cnt != CW'(NB - 1)) begin
                        sr       <= sr << 8;
                        byte_cnt <= byte_cnt + 1'b1;
                    end else begin
                        tx_valid <= 1'b0;
                        if (rd_addr == W'(NREG - 1)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                            state   <= LOAD;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: randomized self-checking bench for regfile_dump_reader
module tb_regfile_dump_reader;
    localparam int B = 32, W = 5, NREG = 32, NB = B / 8, NBYTES = NREG * NB;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, tx_ready = 1'b0;
    logic [W-1:0] rd_addr;
    logic [B-1:0] rd_data;
    logic [7:0] tx_data;
    logic tx_valid, busy, done;
    logic [B-1:0] mem [NREG];
    int n_cmp = 0, n_err = 0, cyc = 0;
    logic [7:0] got[$];
    int got_cyc[$];
    int done_cyc[$];
    logic [7:0] exp_q[$];
    int stall_cnt = 0, stall_err = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    regfile_dump_reader #(.B(B), .W(W), .NREG(NREG)) dut (
        .clk(clk), .reset(reset), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
    );

    assign rd_data = mem[rd_addr];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            if (prev_stall && (!tx_valid || tx_data !== prev_byte)) stall_err++;
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                got_cyc.push_back(cyc);
            end
            if (tx_valid && !tx_ready) stall_cnt++;
            if (done) done_cyc.push_back(cyc);
            prev_stall = tx_valid && !tx_ready;
            prev_byte  = tx_data;
        end else prev_stall = 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task step;
        @(posedge clk);
        #1;
    endtask

    task clear;
        got.delete();
        got_cyc.delete();
        done_cyc.delete();
        stall_cnt = 0;
        stall_err = 0;
    endtask

    task fill_exp;
        exp_q.delete();
        for (int n = 0; n < NREG; n++)
            for (int j = 0; j < NB; j++)
                exp_q.push_back(8'(mem[n] >> (8 * (NB - 1 - j))));
    endtask

    task randomize_mem;
        for (int i = 0; i < NREG; i++) mem[i] = $urandom;
    endtask

    task start_dump(output int c0);
        start = 1'b1;
        c0 = cyc;
        step;
        start = 1'b0;
    endtask

    task wait_done(input int n, input int budget, input bit toggle, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (done_cyc.size() >= n) break;
            if (toggle) tx_ready = ~tx_ready;
            step;
        end
        tx_ready = 1'b1;
        n_cmp++;
        if (done_cyc.size() < n) begin
            n_err++;
            $display("FAIL %s_done_wait: got %0d done pulses, required %0d", tag, done_cyc.size(), n);
        end
    endtask

    task check_stream(input string tag);
        n_cmp++;
        if (got.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL %s_count: got %0d bytes, required %0d", tag, got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s_byte%0d: got %h, required %h", tag, i, got[i], exp_q[i]);
            end
        end
    endtask

    task test_reset;
        #2 reset = 1'b0;
        step;
        step;
        n_cmp += 5;
        if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_tx_valid: got %b, required 0", tx_valid); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b, required 0", done); end
        if (rd_addr !== '0) begin n_err++; $display("FAIL rst_rd_addr: got %h, required 0", rd_addr); end
        if (tx_data !== 8'h00) begin n_err++; $display("FAIL rst_tx_data: got %h, required 00", tx_data); end
        reset = 1'b1;
        step;
    endtask

    task test_basic;
        int c0, bad;
        for (int i = 0; i < NREG; i++) mem[i] = B'(i);
        clear;
        tx_ready = 1'b1;
        start_dump(c0);
        wait_done(1, 400, 1'b0, "basic");
        fill_exp;
        check_stream("basic");
        bad = 0;
        for (int i = 0; i < got_cyc.size(); i++)
            if (got_cyc[i] != c0 + 2 + 5 * (i / NB) + i % NB) bad++;
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL basic_byte_timing: %0d bytes off schedule, required 0", bad); end
        n_cmp++;
        if (done_cyc.size() != 1 || done_cyc[0] != c0 + 5 * NREG + 1) begin
            n_err++;
            $display("FAIL basic_done_cycle: got %0d (pulses %0d), required %0d",
                     done_cyc.size() > 0 ? done_cyc[0] - c0 : -1, done_cyc.size(), 5 * NREG + 1);
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after: got %b, required 0", busy); end
    endtask

    task test_toggle_stall;
        int c0;
        logic [31:0] w;
        randomize_mem;
        mem[16] = 32'hDEADBEEF;
        clear;
        tx_ready = 1'b1;
        start_dump(c0);
        wait_done(1, 800, 1'b1, "toggle");
        fill_exp;
        check_stream("toggle");
        w = 32'h0;
        if (got.size() >= 68) w = {got[64], got[65], got[66], got[67]};
        n_cmp++;
        if (w !== 32'hDEADBEEF) begin n_err++; $display("FAIL toggle_reg16: got %h, required deadbeef", w); end
        n_cmp++;
        if (stall_err != 0) begin n_err++; $display("FAIL toggle_stable: %0d unstable stall cycles, required 0", stall_err); end
        n_cmp++;
        if (done_cyc.size() == 0 || done_cyc[0] != c0 + 5 * NREG + 1 + stall_cnt) begin
            n_err++;
            $display("FAIL toggle_done_cycle: got %0d, required %0d",
                     done_cyc.size() > 0 ? done_cyc[0] - c0 : -1, 5 * NREG + 1 + stall_cnt);
        end
    endtask

    task test_back_to_back;
        int c0, low, dn;
        randomize_mem;
        clear;
        tx_ready = 1'b1;
        start = 1'b1;
        c0 = cyc;
        low = 0;
        dn = 0;
        for (int i = 0; i < 800; i++) begin
            step;
            if (!busy) low++;
            if (done) dn++;
            if (dn == 2) break;
        end
        start = 1'b0;
        repeat (6) step;
        fill_exp;
        exp_q = {exp_q, exp_q};
        check_stream("b2b");
        n_cmp++;
        if (done_cyc.size() != 2) begin n_err++; $display("FAIL b2b_done_count: got %0d, required 2", done_cyc.size()); end
        n_cmp++;
        if (low != 1) begin n_err++; $display("FAIL b2b_busy_gap: got %0d low cycles, required 1", low); end
        n_cmp++;
        if (done_cyc.size() < 2 || done_cyc[0] != c0 + 161 || done_cyc[1] != c0 + 323) begin
            n_err++;
            $display("FAIL b2b_done_cycles: got %0d/%0d, required 161/323",
                     done_cyc.size() > 0 ? done_cyc[0] - c0 : -1, done_cyc.size() > 1 ? done_cyc[1] - c0 : -1);
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_end: got %b, required 0", busy); end
    endtask

    task test_reset_mid;
        int c0;
        randomize_mem;
        clear;
        tx_ready = 1'b1;
        start_dump(c0);
        for (int i = 0; i < 100 && got.size() < 10; i++) step;
        #1 reset = 1'b0;
        #1;
        n_cmp += 4;
        if (tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_tx_valid: got %b, required 0", tx_valid); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
        if (done !== 1'b0) begin n_err++; $display("FAIL mid_rst_done: got %b, required 0", done); end
        if (rd_addr !== '0) begin n_err++; $display("FAIL mid_rst_rd_addr: got %h, required 0", rd_addr); end
        step;
        step;
        reset = 1'b1;
        step;
        n_cmp++;
        if (done_cyc.size() != 0) begin n_err++; $display("FAIL mid_rst_no_done: got %0d pulses, required 0", done_cyc.size()); end
        clear;
        start_dump(c0);
        wait_done(1, 400, 1'b0, "mid_rst");
        fill_exp;
        n_cmp++;
        if (got.size() == 0 || got[0] !== mem[0][31:24]) begin
            n_err++;
            $display("FAIL mid_rst_first_byte: got %h, required %h", got.size() > 0 ? got[0] : 8'hxx, mem[0][31:24]);
        end
        check_stream("mid_rst");
    endtask

    task test_long_stall;
        int c0, bad_v, bad_d, bad_a;
        for (int i = 0; i < NREG; i++) mem[i] = B'(i);
        clear;
        tx_ready = 1'b0;
        start_dump(c0);
        step;
        bad_v = 0;
        bad_d = 0;
        bad_a = 0;
        for (int k = 0; k < 50; k++) begin
            if (tx_valid !== 1'b1) bad_v++;
            if (tx_data !== 8'h00) bad_d++;
            if (rd_addr !== '0) bad_a++;
            step;
        end
        n_cmp += 3;
        if (bad_v != 0) begin n_err++; $display("FAIL stall_valid: %0d cycles low, required 0", bad_v); end
        if (bad_d != 0) begin n_err++; $display("FAIL stall_data: %0d cycles not 00, required 0", bad_d); end
        if (bad_a != 0) begin n_err++; $display("FAIL stall_addr: %0d cycles not 0, required 0", bad_a); end
        tx_ready = 1'b1;
        wait_done(1, 400, 1'b0, "stall");
        fill_exp;
        check_stream("stall");
        n_cmp++;
        if (done_cyc.size() == 0 || done_cyc[0] != c0 + 5 * NREG + 1 + 50) begin
            n_err++;
            $display("FAIL stall_done_cycle: got %0d, required %0d",
                     done_cyc.size() > 0 ? done_cyc[0] - c0 : -1, 5 * NREG + 51);
        end
    endtask

    task test_coherency;
        int c0;
        logic [31:0] w;
        randomize_mem;
        mem[5] = ~32'h12345678;
        clear;
        tx_ready = 1'b1;
        start_dump(c0);
        for (int i = 0; i < 100 && got.size() < 13; i++) step;
        @(negedge clk);
        mem[5] = 32'h12345678;
        wait_done(1, 400, 1'b0, "coh");
        fill_exp;
        check_stream("coh");
        w = 32'h0;
        if (got.size() >= 24) w = {got[20], got[21], got[22], got[23]};
        n_cmp++;
        if (w !== 32'h12345678) begin n_err++; $display("FAIL coh_reg5: got %h, required 12345678", w); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_toggle_stall;
        test_back_to_back;
        test_reset_mid;
        test_long_stall;
        test_coherency;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
